uart_tx_framer: RTL and testbench

- Sequential UART transmit framer and the parametrised successor to the combinational parity generator.
- Accepts one character per valid/ready handshake and serialises it as start bit, 5-8 data bits (LSB first), optional parity bit, then stop bits.
- Adds stick parity, 1/1.5/2 stop bits, break control and per-frame configuration latching.
- Sits between the TX holding register/FIFO and the serial pin. Bit timing comes from the shared baud generator via an oversampled tick.

---
 rtl/uart_tx_framer.sv | 193 +++++++++++++++++++
 tb/tb_uart_tx_framer.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// UART transmit framer. Takes one character per valid/ready handshake and shifts it out as:
// start bit, 5..8 data bits (LSB first), optional parity bit, then 1, 1.5 or 2 stop bits.
// Bit timing comes from an external oversampled baud tick (OSR ticks per bit).
// The character and its framing options are captured at transfer. Break (BC) forces the
// line low without disturbing frame timing.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   baud_tick         one-cycle pulse, OSR per bit period
//   tx_data/tx_valid  character and its valid; tx_ready is high only while idle
//   WLS, STB, PEN,    word length, stop bits, parity enable,
//   EPS, SP           even parity select, stick parity (all captured at transfer)
//   BC                break control (live, registered into tx_o)
//   tx_o              serial line, idle high
//   tx_busy           frame in progress
//   frame_done        one-cycle pulse after the last stop tick
module uart_tx_framer #(
  parameter int unsigned OSR    = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              baud_tick,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [1:0]        WLS,
  input  logic              STB,
  input  logic              PEN,
  input  logic              EPS,
  input  logic              SP,
  input  logic              BC,
  output logic              tx_o,
  output logic              tx_busy,
  output logic              frame_done
);

  localparam int unsigned CntW = $clog2(2 * OSR);
  localparam int unsigned IdxW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Terminal tick counts (last tick index) for a normal bit and the long stop variants.
  localparam logic [CntW-1:0] CntBitLast   = CntW'(OSR - 1);
  localparam logic [CntW-1:0] CntStop15Last = CntW'((3 * OSR) / 2 - 1);
  localparam logic [CntW-1:0] CntStop2Last  = CntW'(2 * OSR - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        wls_q, wls_d;
  logic              stb_q, stb_d;
  logic              pen_q, pen_d;
  logic              par_q, par_d;
  logic              tx_q, tx_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] wls_mask;
  logic              par_in;
  logic [CntW-1:0]   cnt_last;
  logic [IdxW-1:0]   idx_last;
  logic              bit_end;
  logic              fsm_bit;

  // Parity of the incoming character over the WLS-selected bits only.
  always_comb begin
    wls_mask = '0;
    for (int i = 0; i < DATA_W; i++) begin
      wls_mask[i] = (i < 5 + int'(WLS));
    end
    if (SP) begin
      par_in = ~EPS;
    end else if (EPS) begin
      par_in = ^(tx_data & wls_mask);
    end else begin
      par_in = ~^(tx_data & wls_mask);
    end
  end

  always_comb begin
    cnt_last = CntBitLast;
    if (state_q == StStop && stb_q) begin
      cnt_last = (wls_q == 2'b00) ? CntStop15Last : CntStop2Last;
    end
  end

  assign idx_last = IdxW'(3'd4 + 3'(wls_q));
  assign bit_end  = baud_tick && (cnt_q == cnt_last);

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      wls_q   <= '0;
      stb_q   <= 1'b0;
      pen_q   <= 1'b0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      wls_q   <= wls_d;
      stb_q   <= stb_d;
      pen_q   <= pen_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    par_d   = par_q;
    unique case (state_q)
      StIdle: begin
        if (tx_valid) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = tx_data;
          wls_d   = WLS;
          stb_d   = STB;
          pen_d   = PEN;
          par_d   = par_in;
        end
      end
      StStart, StData, StParity, StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          unique case (state_q)
            StStart: begin
              state_d = StData;
              idx_d   = '0;
            end
            StData: begin
              if (idx_q == idx_last) begin
                state_d = pen_q ? StParity : StStop;
              end else begin
                idx_d = idx_q + IdxW'(1);
              end
            end
            StParity: state_d = StStop;
            default:  state_d = StIdle;
          endcase
        end else if (baud_tick) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs are computed from the next state so they line up with it.
  always_comb begin
    fsm_bit = 1'b1;
    unique case (state_d)
      StStart:  fsm_bit = 1'b0;
      StData:   fsm_bit = data_d[idx_d];
      StParity: fsm_bit = par_d;
      default:  fsm_bit = 1'b1;
    endcase
    tx_d    = BC ? 1'b0 : fsm_bit;
    ready_d = (state_d == StIdle);
    busy_d  = (state_d != StIdle);
    done_d  = (state_q == StStop) && (state_d == StIdle);
  end

  assign tx_o       = tx_q;
  assign tx_ready   = ready_q;
  assign tx_busy    = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: line is sampled on every baud tick while busy and compared against a
// per-tick frame model built from the framing rules.
module tb_uart_tx_framer;

  localparam int unsigned OSR        = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int          TICK_DIV   = 3;
  localparam int          HS_LIMIT   = 50;
  localparam int          DONE_LIMIT = 2000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baud_tick;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] WLS;
  logic       STB, PEN, EPS, SP, BC;
  logic       tx_o, tx_busy, frame_done;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int tick_ph = 0;

  logic obs_q[$];
  bit   obs_bc_q[$];
  bit   exp_q[$];
  bit   bc_prev = 1'b0;

  uart_tx_framer #(
    .OSR    (OSR),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .baud_tick  (baud_tick),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .WLS        (WLS),
    .STB        (STB),
    .PEN        (PEN),
    .EPS        (EPS),
    .SP         (SP),
    .BC         (BC),
    .tx_o       (tx_o),
    .tx_busy    (tx_busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick_ph   = (tick_ph == TICK_DIV - 1) ? 0 : tick_ph + 1;
      baud_tick = (tick_ph == 0);
    end
  end

  // Line monitor: one sample per counted tick, tagged with whether break was in effect.
  always @(negedge clk) begin
    if (tx_busy && baud_tick) begin
      obs_q.push_back(tx_o);
      obs_bc_q.push_back(bc_prev);
    end
    if (frame_done) done_cnt++;
    bc_prev = BC;
  end

  // Expected per-tick line level for one frame.
  function automatic void model_append(input logic [7:0] d, input logic [1:0] w,
                                       input logic s, input logic p, input logic e,
                                       input logic k);
    int n;
    int ones;
    int stop_ticks;
    bit par;
    n    = 5 + int'(w);
    ones = 0;
    for (int i = 0; i < n; i++) ones += int'(d[i]);
    if (k)      par = !e;
    else if (e) par = (ones % 2) == 1;
    else        par = (ones % 2) == 0;
    stop_ticks = !s ? OSR : ((w == 2'b00) ? (OSR * 3) / 2 : OSR * 2);
    for (int t = 0; t < OSR; t++) exp_q.push_back(1'b0);
    for (int b = 0; b < n; b++)
      for (int t = 0; t < OSR; t++) exp_q.push_back(d[b]);
    if (p) for (int t = 0; t < OSR; t++) exp_q.push_back(par);
    for (int t = 0; t < stop_ticks; t++) exp_q.push_back(1'b1);
  endfunction

  function automatic int first_diff();
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      if (obs_q[i] !== (obs_bc_q[i] ? 1'b0 : exp_q[i])) return i;
    end
    return -1;
  endfunction

  task automatic clear_queues();
    obs_q.delete();
    obs_bc_q.delete();
    exp_q.delete();
  endtask

  // Present a character, wait for the handshake, then scramble inputs to exercise latching.
  task automatic start_frame(input logic [7:0] d, input logic [1:0] w, input logic s,
                             input logic p, input logic e, input logic k);
    bit hs_ok;
    @(posedge clk);
    #1;
    tx_data = d; WLS = w; STB = s; PEN = p; EPS = e; SP = k; tx_valid = 1'b1;
    hs_ok = 1'b0;
    for (int i = 0; i < HS_LIMIT && !hs_ok; i++) begin
      @(negedge clk);
      if (tx_ready) hs_ok = 1'b1;
    end
    if (!hs_ok) begin
      n_cmp++; n_bad++;
      $display("FAIL handshake_timeout: tx_ready=%b required 1 within %0d cycles", tx_ready,
               HS_LIMIT);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    WLS      = 2'($urandom);
    STB      = 1'($urandom);
    PEN      = 1'($urandom);
    EPS      = 1'($urandom);
    SP       = 1'($urandom);
    model_append(d, w, s, p, e, k);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < DONE_LIMIT && !ok; i++) begin
      @(negedge clk);
      if (frame_done) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL frame_done_timeout: no frame_done within %0d cycles", DONE_LIMIT);
    end
  endtask

  task automatic wait_ticks(input int target);
    for (int i = 0; i < DONE_LIMIT && obs_q.size() < target; i++) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; WLS = '0;
    STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0; BC = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (tx_o !== 1'b1) begin n_bad++; $display("FAIL reset_tx_o: got %b want 1", tx_o); end
    n_cmp++; if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
    n_cmp++; if (frame_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", frame_done); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_even_8bit();
    bit pat[11];
    int bad_bits;
    int d0;
    int df;
    pat = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    clear_queues();
    d0 = done_cnt;
    start_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_done();
    n_cmp++;
    if (obs_q.size() != 176) begin
      n_bad++; $display("FAIL a5_length: got %0d ticks want 176", obs_q.size());
    end
    bad_bits = 0;
    for (int b = 0; b < 11; b++) if (obs_q[b * OSR + OSR / 2] !== pat[b]) bad_bits++;
    n_cmp++;
    if (bad_bits != 0) begin n_bad++; $display("FAIL a5_pattern: %0d bits wrong, want 0", bad_bits); end
    df = first_diff();
    n_cmp++;
    if (df != -1) begin
      n_bad++; $display("FAIL a5_model: tick %0d got %b want %b", df, obs_q[df], exp_q[df]);
    end
    @(negedge clk);
    n_cmp++;
    if (frame_done !== 1'b0 || done_cnt - d0 != 1) begin
      n_bad++; $display("FAIL a5_done_pulse: frame_done=%b count=%0d want 0 and 1", frame_done,
                        done_cnt - d0);
    end
  endtask

  task automatic test_odd_5bit_15stop();
    int df;
    clear_queues();
    start_frame(8'hFF, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done();
    n_cmp++;
    if (obs_q.size() != 7 * OSR + 24) begin
      n_bad++; $display("FAIL ff5_length: got %0d ticks want %0d", obs_q.size(), 7 * OSR + 24);
    end
    n_cmp++;
    if (obs_q[6 * OSR] !== 1'b0) begin
      n_bad++; $display("FAIL ff5_parity: got %b want 0", obs_q[6 * OSR]);
    end
    df = first_diff();
    n_cmp++;
    if (df != -1) begin
      n_bad++; $display("FAIL ff5_model: tick %0d got %b want %b", df, obs_q[df], exp_q[df]);
    end
  endtask

  task automatic test_stick_parity();
    logic want;
    for (int e = 0; e < 2; e++) begin
      want = (e == 0) ? 1'b1 : 1'b0;
      clear_queues();
      start_frame(8'h01, 2'b11, 1'b0, 1'b1, 1'(e), 1'b1);
      wait_done();
      n_cmp++;
      if (obs_q[9 * OSR + 3] !== want) begin
        n_bad++; $display("FAIL stick_parity_eps%0d: got %b want %b", e, obs_q[9 * OSR + 3], want);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit hs_ok;
    int d0;
    int df;
    clear_queues();
    d0 = done_cnt;
    @(posedge clk);
    #1;
    tx_data = 8'h55; WLS = 2'b11; STB = 1'b0; PEN = 1'b0; EPS = 1'b0; SP = 1'b0;
    tx_valid = 1'b1;
    hs_ok = 1'b0;
    for (int i = 0; i < HS_LIMIT && !hs_ok; i++) begin
      @(negedge clk);
      if (tx_ready) hs_ok = 1'b1;
    end
    @(posedge clk);
    #1;
    // Second character and a shorter word length, presented while frame 1 is in flight.
    tx_data = 8'h0F; WLS = 2'b10; PEN = 1'b1; EPS = 1'b1;
    model_append(8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    model_append(8'h0F, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_done();
    n_cmp++;
    if (tx_ready !== 1'b1) begin n_bad++; $display("FAIL b2b_ready_at_done: got %b want 1", tx_ready); end
    @(negedge clk);
    n_cmp++;
    if (tx_busy !== 1'b1 || tx_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_no_gap: busy=%b tx_o=%b want 1 0", tx_busy, tx_o);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    wait_done();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || done_cnt - d0 != 2) begin
      n_bad++; $display("FAIL b2b_length: got %0d ticks %0d frames want %0d ticks 2 frames",
                        obs_q.size(), done_cnt - d0, exp_q.size());
    end
    df = first_diff();
    n_cmp++;
    if (df != -1) begin
      n_bad++; $display("FAIL b2b_model: tick %0d got %b want %b", df, obs_q[df], exp_q[df]);
    end
  endtask

  task automatic test_break();
    int df;
    int base;
    clear_queues();
    start_frame(8'hA5, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    wait_ticks(OSR + 20);
    @(posedge clk);
    #1;
    BC = 1'b1;
    base = obs_q.size();
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (tx_o !== 1'b0) begin n_bad++; $display("FAIL break_low: got %b want 0", tx_o); end
    wait_ticks(base + 40);
    @(posedge clk);
    #1;
    BC = 1'b0;
    wait_done();
    n_cmp++;
    if (obs_q.size() != 176) begin
      n_bad++; $display("FAIL break_length: got %0d ticks want 176", obs_q.size());
    end
    df = first_diff();
    n_cmp++;
    if (df != -1) begin
      n_bad++; $display("FAIL break_model: tick %0d got %b want %b", df, obs_q[df], exp_q[df]);
    end
  endtask

  task automatic test_random();
    int df;
    for (int f = 0; f < 16; f++) begin
      clear_queues();
      start_frame(8'($urandom), 2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom));
      wait_done();
      df = first_diff();
      n_cmp++;
      if (obs_q.size() != exp_q.size() || df != -1) begin
        n_bad++; $display("FAIL random_frame%0d: len %0d first diff %0d want len %0d no diff", f,
                          obs_q.size(), df, exp_q.size());
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int df;
    clear_queues();
    start_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ticks(OSR + 8);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (tx_o !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      n_bad++; $display("FAIL midreset_async: tx_o=%b ready=%b busy=%b want 1 1 0", tx_o, tx_ready,
                        tx_busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_queues();
    start_frame(8'hC3, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_done();
    df = first_diff();
    n_cmp++;
    if (obs_q.size() != exp_q.size() || df != -1) begin
      n_bad++; $display("FAIL after_reset_frame: len %0d first diff %0d want len %0d no diff",
                        obs_q.size(), df, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_even_8bit();
    test_odd_5bit_15stop();
    test_stick_parity();
    test_back_to_back();
    test_break();
    test_random();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
